// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port shared by the VGA frame reader (master) and the
// backing 8-bit registered RAM (slave). The RAM has a one-cycle read latency.
interface vga_frame_reader_if;
  logic [16:0] rd_address;
  logic [7:0]  rd_data;

  modport master (output rd_address, input rd_data);
  modport slave  (input rd_address, output rd_data);
endinterface

// File: rtl/vga_frame_reader.sv
// VGA frame reader: scans a 320x240 grayscale frame buffer and shows each
// buffer pixel as a 2x2 block on a 640x480 raster. Counter-to-pin latency is
// three cycles; syncs and blank are delayed to stay aligned with pixel data.
// Optional feature: define VGA_TEST_PATTERN_EN to enable eight vertical grey
// bars on the output while i_test_mode is high.
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  vga_frame_reader_if.master         fb,
  input  logic                       i_test_mode,
  output logic                       o_hsync,
  output logic                       o_vsync,
  output logic                       o_blank_n,
  output logic [7:0]                 o_vga_r,
  output logic [7:0]                 o_vga_g,
  output logic [7:0]                 o_vga_b,
  output logic                       o_frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned HsBeg  = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VsBeg  = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd  = V_ACTIVE + V_FP + V_SYNC;
  // Buffer words per line: half the visible width (2x horizontal scaling).
  localparam logic [16:0] LineWords = 17'(H_ACTIVE / 2);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [16:0]   r_rd_address;
  logic          r_s1_vis, r_s1_hs_n, r_s1_vs_n;
  logic          r_s2_vis, r_s2_hs_n, r_s2_vs_n;
  logic          r_hsync, r_vsync, r_blank_n;
  logic [7:0]    r_pix;

  logic          w_h_last, w_v_last, w_visible, w_hs_n, w_vs_n;
  logic [16:0]   w_addr;
  logic [7:0]    w_pix;

  assign w_h_last  = (r_h_cnt == HW'(HTotal - 1));
  assign w_v_last  = (r_v_cnt == VW'(VTotal - 1));
  assign w_visible = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs_n    = !((r_h_cnt >= HW'(HsBeg)) && (r_h_cnt < HW'(HsEnd)));
  assign w_vs_n    = !((r_v_cnt >= VW'(VsBeg)) && (r_v_cnt < VW'(VsEnd)));
  assign w_addr    = 17'(r_v_cnt >> 1) * LineWords + 17'(r_h_cnt >> 1);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [HW-1:0] BarWidth = HW'(H_ACTIVE / 8);
  logic [2:0] r_s1_bar, r_s2_bar;
  logic [2:0] w_bar;
  assign w_bar = 3'(r_h_cnt / BarWidth);

  // Carry the bar index alongside the visible flag through stages 1 and 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_bar <= '0;
      r_s2_bar <= '0;
    end else begin
      r_s1_bar <= w_bar;
      r_s2_bar <= r_s1_bar;
    end
  end

  // Pixel select: test bars override frame-buffer data inside the visible area.
  always_comb begin
    w_pix = 8'h00;
    if (r_s2_vis) begin
      w_pix = i_test_mode ? {r_s2_bar, 5'b11111} : fb.rd_data;
    end
  end
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = i_test_mode;

  // Pixel select: frame-buffer data inside the visible area, black elsewhere.
  always_comb begin
    w_pix = 8'h00;
    if (r_s2_vis) begin
      w_pix = fb.rd_data;
    end
  end
`endif

  // Raster position counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Stage 1: issue the buffer read and capture timing flags for this position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_address <= '0;
      r_s1_vis     <= 1'b0;
      r_s1_hs_n    <= 1'b1;
      r_s1_vs_n    <= 1'b1;
    end else begin
      r_rd_address <= w_visible ? w_addr : 17'd0;
      r_s1_vis     <= w_visible;
      r_s1_hs_n    <= w_hs_n;
      r_s1_vs_n    <= w_vs_n;
    end
  end

  // Stage 2 covers the RAM read latency; stage 3 registers the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vis  <= 1'b0;
      r_s2_hs_n <= 1'b1;
      r_s2_vs_n <= 1'b1;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
      r_pix     <= 8'h00;
    end else begin
      r_s2_vis  <= r_s1_vis;
      r_s2_hs_n <= r_s1_hs_n;
      r_s2_vs_n <= r_s1_vs_n;
      r_hsync   <= r_s2_hs_n;
      r_vsync   <= r_s2_vs_n;
      r_blank_n <= r_s2_vis;
      r_pix     <= w_pix;
    end
  end

  assign fb.rd_address = r_rd_address;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_blank_n     = r_blank_n;
  assign o_vga_r       = r_pix;
  assign o_vga_g       = r_pix;
  assign o_vga_b       = r_pix;
  // Undelayed marker; suppressed while reset is held so it fires only on real frames.
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0) && !rst;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader using a reduced 24x13 raster (16x8 visible) so
// whole frames fit in a short run. Position (h,v) at cycle c after reset:
// h = c % 24, v = (c / 24) % 13; address = (v>>1)*8 + (h>>1).
module tb_vga_frame_reader;

  localparam int unsigned FT = 312;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       test_mode = 1'b0;
  logic       hsync, vsync, blank_n, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_frame_reader_if fb ();

  vga_frame_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fb           (fb.master),
    .i_test_mode  (test_mode),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_blank_n    (blank_n),
    .o_vga_r      (vga_r),
    .o_vga_g      (vga_g),
    .o_vga_b      (vga_b),
    .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Registered RAM model: mode 0 returns addr[7:0]^0x80, mode 1 a constant.
  int         data_mode = 0;
  logic [7:0] const_data = 8'hA5;
  always @(posedge clk) begin
    fb.rd_data <= (data_mode == 0) ? (fb.rd_address[7:0] ^ 8'h80) : const_data;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
  endtask

  // Advance to cycle c (c >= current) and sample at the falling edge.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    int   c;
    int   addr;
    logic hs;
    logic vs;
    logic bl;
    int   rgb;
    logic fs;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hs_low, vs_low, bl_high, fs_cnt, rgb_err;
    int   hs_fall0, hs_fall1, hs_run, vs_fall0, vs_fall1, vs_run, fs0, fs1;
    logic prev_hs, prev_vs;
    logic [7:0] tp_exp [4];
    int   tp_cyc [4];

    //          c   addr hs    vs    bl    rgb   fs
    vecs.push_back('{0,   0, 1'b1, 1'b1, 1'b0, 0,    1'b1});
    vecs.push_back('{1,   0, 1'b1, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{3,   1, 1'b1, 1'b1, 1'b1, 'h80, 1'b0});
    vecs.push_back('{4,   1, 1'b1, 1'b1, 1'b1, 'h80, 1'b0});
    vecs.push_back('{5,   2, 1'b1, 1'b1, 1'b1, 'h81, 1'b0});
    vecs.push_back('{17,  0, 1'b1, 1'b1, 1'b1, 'h87, 1'b0});
    vecs.push_back('{19,  0, 1'b1, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{21,  0, 1'b0, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{23,  0, 1'b0, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{24,  0, 1'b1, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{26,  0, 1'b1, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{30,  2, 1'b1, 1'b1, 1'b1, 'h81, 1'b0});
    vecs.push_back('{50,  8, 1'b1, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{52,  9, 1'b1, 1'b1, 1'b1, 'h88, 1'b0});
    vecs.push_back('{184, 31, 1'b1, 1'b1, 1'b1, 'h9E, 1'b0});
    vecs.push_back('{186, 0, 1'b1, 1'b1, 1'b1, 'h9F, 1'b0});
    vecs.push_back('{219, 0, 1'b1, 1'b0, 1'b0, 0,    1'b0});
    vecs.push_back('{266, 0, 1'b1, 1'b0, 1'b0, 0,    1'b0});
    vecs.push_back('{267, 0, 1'b1, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{312, 0, 1'b1, 1'b1, 1'b0, 0,    1'b1});
    vecs.push_back('{313, 0, 1'b1, 1'b1, 1'b0, 0,    1'b0});
    vecs.push_back('{315, 1, 1'b1, 1'b1, 1'b1, 'h80, 1'b0});

    reset_dut(3);
    foreach (vecs[i]) begin
      goto(vecs[i].c);
      chk($sformatf("vec%0d_addr", i), fb.rd_address, vecs[i].addr);
      chk($sformatf("vec%0d_hsync", i), hsync, vecs[i].hs);
      chk($sformatf("vec%0d_vsync", i), vsync, vecs[i].vs);
      chk($sformatf("vec%0d_blank_n", i), blank_n, vecs[i].bl);
      chk($sformatf("vec%0d_r", i), vga_r, vecs[i].rgb);
      chk($sformatf("vec%0d_g", i), vga_g, vecs[i].rgb);
      chk($sformatf("vec%0d_b", i), vga_b, vecs[i].rgb);
      chk($sformatf("vec%0d_frame_start", i), frame_start, vecs[i].fs);
    end

    // Two full frames of sync/blank statistics with constant 0xA5 data.
    data_mode = 1;
    const_data = 8'hA5;
    hs_low = 0; vs_low = 0; bl_high = 0; fs_cnt = 0; rgb_err = 0;
    hs_fall0 = -1; hs_fall1 = -1; vs_fall0 = -1; vs_fall1 = -1; fs0 = -1; fs1 = -1;
    hs_run = 0; vs_run = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
    for (int c = 330; c < 330 + 2 * FT; c++) begin
      goto(c);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (blank_n) bl_high++;
      if (blank_n ? (vga_r !== 8'hA5) : (vga_r !== 8'h00)) rgb_err++;
      if (prev_hs && !hsync) begin
        if (hs_fall0 < 0) hs_fall0 = c; else if (hs_fall1 < 0) hs_fall1 = c;
      end
      if (!hsync && hs_fall1 < 0 && hs_fall0 >= 0) hs_run++;
      if (prev_vs && !vsync) begin
        if (vs_fall0 < 0) vs_fall0 = c; else if (vs_fall1 < 0) vs_fall1 = c;
      end
      if (!vsync && vs_fall1 < 0 && vs_fall0 >= 0) vs_run++;
      if (frame_start) begin
        fs_cnt++;
        if (fs0 < 0) fs0 = c; else if (fs1 < 0) fs1 = c;
      end
      prev_hs = hsync;
      prev_vs = vsync;
    end
    chk("hsync_low_total", hs_low, 2 * 13 * 3);
    chk("hsync_width", hs_run, 3);
    chk("hsync_period", hs_fall1 - hs_fall0, 24);
    chk("vsync_low_total", vs_low, 2 * 2 * 24);
    chk("vsync_width", vs_run, 48);
    chk("vsync_period", vs_fall1 - vs_fall0, FT);
    chk("blank_high_total", bl_high, 2 * 8 * 16);
    chk("a5_rgb_errors", rgb_err, 0);
    chk("frame_start_count", fs_cnt, 2);
    chk("frame_start_first", fs0, 2 * FT);
    chk("frame_start_period", fs1 - fs0, FT);

    // One-cycle reset in mid-frame at position (10,5).
    reset_dut(2);
    goto(130);
    chk("pre_rst_blank_n", blank_n, 1);
    chk("pre_rst_rgb", vga_r, 'hA5);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    goto(0);
    chk("post_rst_frame_start", frame_start, 1);
    chk("post_rst_addr", fb.rd_address, 0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) goto(c);
      chk($sformatf("post_rst%0d_hsync", c), hsync, 1);
      chk($sformatf("post_rst%0d_vsync", c), vsync, 1);
      chk($sformatf("post_rst%0d_blank_n", c), blank_n, 0);
      chk($sformatf("post_rst%0d_rgb", c), vga_r, 0);
    end
    goto(3);
    chk("post_rst3_blank_n", blank_n, 1);
    chk("post_rst3_rgb", vga_r, 'hA5);
    chk("post_rst3_addr", fb.rd_address, 1);
    chk("post_rst3_frame_start", frame_start, 0);

    // Test-pattern bars (bar width 2 on this raster); data fixed at 0x11.
    const_data = 8'h11;
    test_mode = 1'b1;
    reset_dut(2);
    tp_cyc[0] = 3;  tp_cyc[1] = 6;  tp_cyc[2] = 10; tp_cyc[3] = 18;
`ifdef VGA_TEST_PATTERN_EN
    tp_exp[0] = 8'h1F; tp_exp[1] = 8'h3F; tp_exp[2] = 8'h7F; tp_exp[3] = 8'hFF;
`else
    tp_exp[0] = 8'h11; tp_exp[1] = 8'h11; tp_exp[2] = 8'h11; tp_exp[3] = 8'h11;
`endif
    for (int i = 0; i < 4; i++) begin
      goto(tp_cyc[i]);
      chk($sformatf("tp%0d_rgb", i), vga_g, int'(tp_exp[i]));
      chk($sformatf("tp%0d_blank_n", i), blank_n, 1);
    end
    goto(21);
    chk("tp_blank_rgb", vga_b, 0);
    test_mode = 1'b0;
    goto(27);
    chk("tp_off_rgb0", vga_r, 'h11);
    goto(30);
    chk("tp_off_rgb1", vga_b, 'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
